// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_if
//  Description : Bus interface for the multi-cycle MULTU/DIVU sequencer.
//                Carries the CPU request/result signals and the borrowed
//                ALU operand/result lines. The master side is the CPU/ALU
//                environment; the slave side is muldiv_seq.
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);

  // Request from the CPU
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // Status and results back to the CPU
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Time-shared ALU lines
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output start, op, a, b, alu_result,
    input  busy, done, hi, lo, alu_a, alu_b, alu_op
  );

  modport slave (
    input  start, op, a, b, alu_result,
    output busy, done, hi, lo, alu_a, alu_b, alu_op
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative unsigned multiply/divide sequencer (MULTU/DIVU).
//                One shift-add (multiply) or restoring shift-subtract
//                (divide) step per clock for WIDTH steps, using the CPU's
//                combinational ALU for the add/subtract. Results are held
//                in HI/LO until the next completion.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);

  localparam logic [3:0]       c_ALU_ADD = 4'b0000;
  localparam logic [3:0]       c_ALU_SUB = 4'b0100;
  localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Sequencer state and registered status outputs
  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic             op_q;
  logic [CNT_W-1:0] cnt_q;

  // Working accumulators: mul uses {P_hi, P_lo} with M in opnd_q,
  // div uses R in acc_hi_q, Q in acc_lo_q and D in opnd_q.
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_hi_d;
  logic [WIDTH-1:0] acc_lo_d;

  // Architectural result registers
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Step datapath
  logic [WIDTH-1:0] w_shift;
  logic             w_msb;
  logic             w_take;
  logic             w_carry;
  logic             w_last;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [3:0]       w_alu_op;

  // Divide view: remainder shifted left with the next dividend bit pulled in.
  // The bit shifted out of R is kept so a 33-bit partial remainder is never
  // mistaken for a value smaller than the divisor.
  assign w_shift = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
  assign w_msb   = acc_hi_q[WIDTH-1];
  assign w_take  = w_msb | (w_shift >= opnd_q);

  // Multiply view: an unsigned add wrapped around iff the sum is smaller
  // than one of its operands, which recovers the 33rd product bit.
  assign w_carry = (bus.alu_result < acc_hi_q);

  assign w_last  = (cnt_q == c_LAST);

  // ALU operand selection; the ALU sees a benign add of zeros outside RUN
  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_op = c_ALU_ADD;
    if (state_q == S_RUN) begin
      if (op_q) begin
        w_alu_a  = w_shift;
        w_alu_b  = opnd_q;
        w_alu_op = c_ALU_SUB;
      end else begin
        w_alu_a  = acc_hi_q;
        w_alu_b  = opnd_q;
        w_alu_op = c_ALU_ADD;
      end
    end
  end

  // Next accumulator values for one iteration of the selected operation
  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    if (op_q) begin
      acc_hi_d = w_take ? bus.alu_result : w_shift;
      acc_lo_d = {acc_lo_q[WIDTH-2:0], w_take};
    end else if (acc_lo_q[0]) begin
      acc_hi_d = {w_carry, bus.alu_result[WIDTH-1:1]};
      acc_lo_d = {bus.alu_result[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      acc_hi_d = {1'b0, acc_hi_q[WIDTH-1:1]};
      acc_lo_d = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sequencer FSM: latch the request, run WIDTH steps, publish and pulse done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      op_q     <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            op_q     <= bus.op;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            if (bus.op) begin
              acc_lo_q <= bus.a;
              opnd_q   <= bus.b;
            end else begin
              acc_lo_q <= bus.b;
              opnd_q   <= bus.a;
            end
          end
        end
        S_RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + c_ONE;
          if (w_last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            hi_q    <= acc_hi_d;
            lo_q    <= acc_lo_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.alu_a  = w_alu_a;
  assign bus.alu_b  = w_alu_b;
  assign bus.alu_op = w_alu_op;

endmodule
`default_nettype wire
